// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader.
// Holds the loader state encoding, the frame constants and a small
// helper that identifies the sticky end states.
package program_loader_pkg;

    typedef enum logic [2:0] {
        LDR_LEN_LO = 3'd0,
        LDR_LEN_HI = 3'd1,
        LDR_DATA   = 3'd2,
        LDR_CHK    = 3'd3,
        LDR_DONE   = 3'd4,
        LDR_ERROR  = 3'd5
    } ldr_state_e;

    // Two little-endian length bytes precede the payload.
    localparam int HDR_LEN = 2;
    // The trailing checksum is the payload sum modulo 2^CHK_W.
    localparam int CHK_W = 8;

    // DONE and ERROR are the only states that accept a start pulse.
    function automatic logic is_final(ldr_state_e s);
        return (s == LDR_DONE) || (s == LDR_ERROR);
    endfunction

endpackage

// File: rtl/program_loader_fsm.sv
// Frame-level control for the program loader.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   start         - re-arm pulse, only honoured in DONE or ERROR
//   xfer          - a stream byte transfers on this edge
//   len_too_big   - length formed in LEN_HI exceeds the payload limit
//   len_zero      - length formed in LEN_HI is zero
//   last_byte     - the current DATA transfer is the final payload byte
//   sum_match     - the incoming byte equals the running checksum
//   state         - current state, used by the datapath
//   in_ready      - loader can accept a byte
//   cpu_rst       - CPU reset, low only in DONE
//   done, error   - registered end-state flags
module program_loader_fsm
    import program_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       xfer,
    input  logic       len_too_big,
    input  logic       len_zero,
    input  logic       last_byte,
    input  logic       sum_match,
    output ldr_state_e state,
    output logic       in_ready,
    output logic       cpu_rst,
    output logic       done,
    output logic       error
);

    ldr_state_e state_q, state_d;
    logic       cpu_rst_q, cpu_rst_d;
    logic       done_q, done_d;
    logic       error_q, error_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LDR_LEN_LO;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LDR_LEN_LO: if (xfer) state_d = LDR_LEN_HI;
            LDR_LEN_HI: begin
                if (xfer) begin
                    if (len_too_big)   state_d = LDR_ERROR;
                    else if (len_zero) state_d = LDR_CHK;
                    else               state_d = LDR_DATA;
                end
            end
            LDR_DATA:   if (xfer && last_byte) state_d = LDR_CHK;
            LDR_CHK:    if (xfer) state_d = sum_match ? LDR_DONE : LDR_ERROR;
            LDR_DONE,
            LDR_ERROR:  if (start) state_d = LDR_LEN_LO;
            default:    state_d = LDR_LEN_LO;
        endcase
        // Flags are decoded from the next state so they change on the
        // same edge as the state itself.
        done_d    = (state_d == LDR_DONE);
        error_d   = (state_d == LDR_ERROR);
        cpu_rst_d = (state_d != LDR_DONE);
    end

    assign state    = state_q;
    assign in_ready = !is_final(state_q);
    assign cpu_rst  = cpu_rst_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader.
// Receives a framed image (LEN_LO, LEN_HI, payload, checksum) over a
// valid/ready byte stream, writes the payload into memory from address 0
// and keeps the CPU in reset until the checksum verifies.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   start                 - re-arm pulse, honoured in DONE or ERROR
//   in_valid, in_data     - incoming stream byte
//   in_ready              - loader can accept a byte
//   mem_we, mem_addr,
//   mem_wdata             - registered memory write port
//   cpu_rst               - CPU reset, released once the image verifies
//   done, error           - frame verified / frame rejected
//   byte_count            - payload bytes written so far
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_BYTES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [15:0]       byte_count
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

    ldr_state_e        state;
    logic              xfer;
    logic              rearm;
    logic [15:0]       n_full;
    logic              len_too_big;
    logic              len_zero;
    logic              last_byte;
    logic              sum_match;

    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [CHK_W-1:0]  sum_q, sum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       count_q, count_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    program_loader_fsm u_fsm (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .xfer        (xfer),
        .len_too_big (len_too_big),
        .len_zero    (len_zero),
        .last_byte   (last_byte),
        .sum_match   (sum_match),
        .state       (state),
        .in_ready    (in_ready),
        .cpu_rst     (cpu_rst),
        .done        (done),
        .error       (error)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            len_lo_q    <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            addr_q      <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        xfer        = in_valid && in_ready;
        rearm       = start && is_final(state);
        // The full length is only meaningful while LEN_HI is transferring.
        n_full      = {in_data, len_lo_q};
        len_too_big = (n_full > MAX_LEN);
        len_zero    = (n_full == 16'd0);
        // count_q already holds the bytes accepted before this one.
        last_byte   = ((count_q + 16'd1) == len_q);
        sum_match   = (in_data == sum_q);

        len_lo_d    = len_lo_q;
        len_d       = len_q;
        sum_d       = sum_q;
        addr_d      = addr_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (rearm) begin
            len_lo_d    = '0;
            len_d       = '0;
            sum_d       = '0;
            addr_d      = '0;
            count_d     = '0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
        end else if (xfer) begin
            case (state)
                LDR_LEN_LO: len_lo_d = in_data;
                LDR_LEN_HI: len_d    = n_full;
                LDR_DATA: begin
                    // The address counter may wrap to 0 after the last
                    // byte of a full-memory image; it is never used again.
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                    addr_d      = addr_q + ADDR_W'(1);
                    sum_d       = sum_q + in_data;
                    count_d     = count_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign byte_count = count_q;

endmodule
